// File: rtl/pipeline_run_ctrl.sv
// Run/step/restart controller producing the global pipeline enable for the five-stage MIPS core.
// Stops on a HALT in writeback and counts enabled cycles with saturation.
module pipeline_run_ctrl #(
  parameter int CNT_W      = 32,
  parameter int STEP_W     = 8,
  parameter int RST_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  input  logic [1:0]        cmd,
  input  logic [STEP_W-1:0] step_n,
  input  logic              halt_w,
  output logic              cmd_ready,
  output logic              pipe_en,
  output logic              pipe_rst,
  output logic              halted,
  output logic              done,
  output logic [2:0]        state,
  output logic [CNT_W-1:0]  cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_STEP    = 3'd2,
    S_PAUSED  = 3'd3,
    S_HALTED  = 3'd4,
    S_RESTART = 3'd5
  } state_t;

  localparam logic [1:0] CMD_PAUSE   = 2'b00;
  localparam logic [1:0] CMD_RUN     = 2'b01;
  localparam logic [1:0] CMD_STEP    = 2'b10;
  localparam logic [1:0] CMD_RESTART = 2'b11;

  state_t              r_state, w_state_nxt;
  logic [STEP_W-1:0]   r_step_cnt, w_step_cnt_nxt;
  logic [3:0]          r_rst_cnt, w_rst_cnt_nxt;
  logic                r_done, w_done_nxt;
  logic [CNT_W-1:0]    r_cycle_count;
  logic                w_accept;
  logic                w_restart;
  logic                w_en;

  assign w_en      = (r_state == S_RUN) || (r_state == S_STEP);
  assign w_accept  = cmd_valid && (r_state != S_RESTART);
  assign w_restart = w_accept && (cmd == CMD_RESTART);

  assign cmd_ready   = (r_state != S_RESTART);
  assign pipe_en     = w_en;
  assign pipe_rst    = (r_state == S_RESTART);
  assign halted      = (r_state == S_HALTED);
  assign done        = r_done;
  assign state       = r_state;
  assign cycle_count = r_cycle_count;

  always_comb begin
    w_state_nxt    = r_state;
    w_step_cnt_nxt = r_step_cnt;
    w_rst_cnt_nxt  = r_rst_cnt;
    w_done_nxt     = 1'b0;
    // RESTART outranks everything, including a HALT arriving on the same edge
    if (w_restart) begin
      w_state_nxt   = S_RESTART;
      w_rst_cnt_nxt = 4'(RST_CYCLES);
    end else begin
      unique case (r_state)
        S_IDLE, S_PAUSED: begin
          if (w_accept && cmd == CMD_RUN) begin
            w_state_nxt = S_RUN;
          end else if (w_accept && cmd == CMD_STEP && step_n != '0) begin
            w_state_nxt    = S_STEP;
            w_step_cnt_nxt = step_n;
          end
        end
        S_RUN: begin
          if (halt_w) begin
            w_state_nxt = S_HALTED;
            w_done_nxt  = 1'b1;
          end else if (w_accept && cmd == CMD_PAUSE) begin
            w_state_nxt = S_PAUSED;
          end
        end
        S_STEP: begin
          w_step_cnt_nxt = r_step_cnt - STEP_W'(1);
          if (halt_w) begin
            w_state_nxt = S_HALTED;
            w_done_nxt  = 1'b1;
          end else if (w_accept && cmd == CMD_PAUSE) begin
            w_state_nxt = S_PAUSED;
          end else if (w_accept && cmd == CMD_RUN) begin
            w_state_nxt = S_RUN;
          end else if (r_step_cnt == STEP_W'(1)) begin
            w_state_nxt = S_PAUSED;
            w_done_nxt  = 1'b1;
          end
        end
        S_HALTED: begin
          w_state_nxt = S_HALTED;
        end
        S_RESTART: begin
          w_rst_cnt_nxt = r_rst_cnt - 4'd1;
          if (r_rst_cnt <= 4'd1) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_step_cnt    <= '0;
      r_rst_cnt     <= '0;
      r_done        <= 1'b0;
      r_cycle_count <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_step_cnt <= w_step_cnt_nxt;
      r_rst_cnt  <= w_rst_cnt_nxt;
      r_done     <= w_done_nxt;
      if (w_restart) begin
        r_cycle_count <= '0;
      end else if (w_en && !(&r_cycle_count)) begin
        r_cycle_count <= r_cycle_count + CNT_W'(1);
      end
    end
  end

endmodule
